// File: rtl/debug_pkg.sv
// Shared constants, state encoding and reply helper for the debug serial link host.
package debug_pkg;

  localparam logic [7:0] CmdNop    = 8'h00;
  localparam logic [7:0] CmdLEDOff = 8'h80;
  localparam logic [7:0] CmdLEDOn  = 8'h81;
  localparam logic [7:0] RespSync  = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HUNT = 2'd2,
    DONE = 2'd3
  } state_e;

  // Two-byte word the target returns for a given command: sync byte then echo.
  function automatic logic [15:0] reply_word(input logic [7:0] cmd);
    return {RespSync, cmd};
  endfunction

endpackage

// File: rtl/debug_clkgen.sv
// Serial clock divider: toggles sclk every ClkDiv cycles while enabled and
// strobes rise_tick / fall_tick in the cycle whose edge makes that toggle.
module debug_clkgen
  import debug_pkg::*;
#(
  parameter int ClkDiv = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int DivW = (ClkDiv > 2) ? $clog2(ClkDiv) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            sclk_q, sclk_d;
  logic            wrap_s;

  // Divider next state; disabling parks the clock low and the counter at zero.
  always_comb begin
    div_d     = div_q;
    sclk_d    = sclk_q;
    wrap_s    = en && (div_q == DivLast);
    rise_tick = wrap_s && !sclk_q;
    fall_tick = wrap_s && sclk_q;
    if (!en) begin
      div_d  = {DivW{1'b0}};
      sclk_d = 1'b0;
    end else if (wrap_s) begin
      div_d  = {DivW{1'b0}};
      sclk_d = !sclk_q;
    end else begin
      div_d  = div_q + DivW'(1);
      sclk_d = sclk_q;
    end
  end

  // Divider and serial clock flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= {DivW{1'b0}};
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/debug_host.sv
// Host-side initiator for the debug serial link: shifts a command byte out MSB
// first, then hunts the returned stream for the sync byte plus echoed command.
module debug_host
  import debug_pkg::*;
#(
  parameter int ClkDiv      = 4,
  parameter int TimeoutBits = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       cmd_err,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_timeout,
  output logic       debug_clk,
  output logic       debug_cs,
  output logic       debug_di,
  input  logic       debug_do
);

  localparam int BitW = $clog2(TimeoutBits + 1);
  localparam int GapW = $clog2(2 * ClkDiv);
  localparam logic [BitW-1:0] BitSend    = BitW'(8);
  localparam logic [BitW-1:0] BitTimeout = BitW'(TimeoutBits);
  localparam logic [GapW-1:0] GapLast    = GapW'(2 * ClkDiv - 1);

  state_e          state_q, state_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      tx_q, tx_d;
  logic [15:0]     sr_q, sr_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            cs_q, cs_d;
  logic            di_q, di_d;
  logic            cmd_err_q, cmd_err_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_timeout_q, resp_timeout_d;
  logic [7:0]      resp_data_q, resp_data_d;

  logic            en_s;
  logic            rise_tick_s;
  logic            fall_tick_s;
  logic [15:0]     sr_next_s;
  logic [BitW-1:0] bit_inc_s;

  assign en_s = (state_q == SEND) || (state_q == HUNT);

  debug_clkgen #(
    .ClkDiv(ClkDiv)
  ) u_clkgen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en_s),
    .sclk     (debug_clk),
    .rise_tick(rise_tick_s),
    .fall_tick(fall_tick_s)
  );

  // Transfer sequencing: accept, shift out, hunt for the reply, then a quiet gap.
  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    tx_d           = tx_q;
    sr_d           = sr_q;
    bit_cnt_d      = bit_cnt_q;
    gap_d          = gap_q;
    cs_d           = cs_q;
    di_d           = di_q;
    resp_data_d    = resp_data_q;
    cmd_err_d      = 1'b0;
    resp_valid_d   = 1'b0;
    resp_timeout_d = 1'b0;
    sr_next_s      = {sr_q[14:0], debug_do};
    bit_inc_s      = (bit_cnt_q == BitTimeout) ? bit_cnt_q : bit_cnt_q + BitW'(1);

    case (state_q)
      IDLE: begin
        cs_d  = 1'b0;
        di_d  = 1'b0;
        gap_d = {GapW{1'b0}};
        if (cmd_valid) begin
          if (cmd_data[7]) begin
            cmd_d     = cmd_data;
            tx_d      = cmd_data;
            di_d      = cmd_data[7];
            cs_d      = 1'b1;
            bit_cnt_d = {BitW{1'b0}};
            state_d   = SEND;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SEND: begin
        // Rising edges are counted so the eighth falling tick ends the byte.
        if (rise_tick_s) begin
          bit_cnt_d = bit_inc_s;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if (fall_tick_s) begin
          if (bit_cnt_q == BitSend) begin
            state_d   = HUNT;
            di_d      = 1'b0;
            sr_d      = 16'h0000;
            bit_cnt_d = {BitW{1'b0}};
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
            di_d = tx_q[6];
          end
        end else begin
          di_d = di_q;
        end
      end

      HUNT: begin
        // Periods are counted on rises; each falling tick samples one reply bit.
        if (rise_tick_s) begin
          bit_cnt_d = bit_inc_s;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if (fall_tick_s) begin
          sr_d = sr_next_s;
          if (sr_next_s == reply_word(cmd_q)) begin
            resp_data_d  = cmd_q;
            resp_valid_d = 1'b1;
            cs_d         = 1'b0;
            state_d      = DONE;
          end else if (bit_cnt_q == BitTimeout) begin
            resp_timeout_d = 1'b1;
            cs_d           = 1'b0;
            state_d        = DONE;
          end else begin
            state_d = HUNT;
          end
        end else begin
          state_d = HUNT;
        end
      end

      DONE: begin
        cs_d = 1'b0;
        di_d = 1'b0;
        if (gap_q == GapLast) begin
          gap_d   = {GapW{1'b0}};
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        di_d    = 1'b0;
      end
    endcase
  end

  // All transfer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_q          <= CmdNop;
      tx_q           <= CmdNop;
      sr_q           <= 16'h0000;
      bit_cnt_q      <= {BitW{1'b0}};
      gap_q          <= {GapW{1'b0}};
      cs_q           <= 1'b0;
      di_q           <= 1'b0;
      cmd_err_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= 8'h00;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      tx_q           <= tx_d;
      sr_q           <= sr_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_q          <= gap_d;
      cs_q           <= cs_d;
      di_q           <= di_d;
      cmd_err_q      <= cmd_err_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_data_q    <= resp_data_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign cmd_err      = cmd_err_q;
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
  assign resp_data    = resp_data_q;
  assign debug_cs     = cs_q;
  assign debug_di     = di_q;

endmodule

// File: tb/tb_debug_host.sv
// Bench for debug_host: two instances (short and long hunt window) share the
// command port; each has its own echoing target. A timeline model predicts
// every output on every cycle from the command, the reply stream and the
// link timing.
module tb_debug_host;
  import debug_pkg::*;

  localparam int C  = 4;
  localparam int TA = 16;
  localparam int TB = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_data;

  logic       ready_a, err_a, rv_a, rt_a, dclk_a, cs_a, di_a;
  logic       ready_b, err_b, rv_b, rt_b, dclk_b, cs_b, di_b;
  logic [7:0] rd_a, rd_b;
  logic       do_a = 1'b0;
  logic       do_b = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // reply stream the targets emit after receiving the command byte
  logic stream [64];
  int   stream_len = 0;

  // target-side state
  logic [7:0] rx_a = 8'h00;
  logic [7:0] rx_b = 8'h00;
  int rxn_a = 0, idx_a = 0, rxn_b = 0, idx_b = 0;

  // timeline model per instance
  bit         act    [2];
  bit         mok    [2];
  int         acc    [2];
  int         mend   [2];
  int         err_at [2];
  logic [7:0] mcmd   [2];
  logic [7:0] mrd    [2];
  // observations
  int nrv [2];
  int nrt [2];
  int nerr[2];
  int pj  [2];

  always #5 clk = ~clk;

  debug_host #(.ClkDiv(C), .TimeoutBits(TA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
    .cmd_data(cmd_data), .cmd_err(err_a), .resp_valid(rv_a), .resp_data(rd_a),
    .resp_timeout(rt_a), .debug_clk(dclk_a), .debug_cs(cs_a), .debug_di(di_a),
    .debug_do(do_a)
  );

  debug_host #(.ClkDiv(C), .TimeoutBits(TB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
    .cmd_data(cmd_data), .cmd_err(err_b), .resp_valid(rv_b), .resp_data(rd_b),
    .resp_timeout(rt_b), .debug_clk(dclk_b), .debug_cs(cs_b), .debug_di(di_b),
    .debug_do(do_b)
  );

  function automatic logic sbit(input int k);
    return (k < stream_len) ? stream[k] : 1'b0;
  endfunction

  // target A: receive 8 bits on rises, then play the reply stream on rises
  always @(posedge dclk_a or negedge cs_a) begin
    if (!cs_a) begin
      rxn_a <= 0;
      idx_a <= 0;
      do_a  <= 1'b0;
    end else if (rxn_a < 8) begin
      rx_a  <= {rx_a[6:0], di_a};
      rxn_a <= rxn_a + 1;
    end else begin
      do_a  <= sbit(idx_a);
      idx_a <= idx_a + 1;
    end
  end

  // target B: same behaviour on the second link
  always @(posedge dclk_b or negedge cs_b) begin
    if (!cs_b) begin
      rxn_b <= 0;
      idx_b <= 0;
      do_b  <= 1'b0;
    end else if (rxn_b < 8) begin
      rx_b  <= {rx_b[6:0], di_b};
      rxn_b <= rxn_b + 1;
    end else begin
      do_b  <= sbit(idx_b);
      idx_b <= idx_b + 1;
    end
  end

  function automatic int tmax(input int i);
    return (i == 0) ? TA : TB;
  endfunction

  // first sample index (1-based) at which the last 16 samples are sync+cmd; 0 = none
  function automatic int resolve(input logic [7:0] c, input int lim);
    logic [15:0] win;
    logic [15:0] want;
    win  = 16'h0000;
    want = {8'h01, c};
    for (int k = 1; k <= lim; k++) begin
      win = {win[14:0], sbit(k - 1)};
      if (win == want) return k;
    end
    return 0;
  endfunction

  // expected {debug_clk, cs, di, ready, resp_valid, resp_timeout, cmd_err, resp_data}
  function automatic logic [14:0] expv(input int i);
    int j;
    logic c, s, d, r, v, t, e;
    j = cyc - acc[i];
    e = (cyc == err_at[i]);
    if (act[i] && (j < mend[i] + 2 * C)) begin
      r = 1'b0;
      if (j < mend[i]) begin
        c = ((j / C) % 2) == 1;
        s = 1'b1;
      end else begin
        c = 1'b0;
        s = 1'b0;
      end
      d = (j < 16 * C) ? mcmd[i][7 - j / (2 * C)] : 1'b0;
      v = (j == mend[i]) && mok[i];
      t = (j == mend[i]) && !mok[i];
    end else begin
      r = 1'b1; c = 1'b0; s = 1'b0; d = 1'b0; v = 1'b0; t = 1'b0;
    end
    return {c, s, d, r, v, t, e, mrd[i]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // one clock: model the accept on the rising edge, compare on the falling edge
  task automatic tick();
    int k;
    int j;
    bit busy;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      busy = act[i] && ((cyc - 1 - acc[i]) < mend[i] + 2 * C);
      if (rst_n && cmd_valid && !busy) begin
        if (cmd_data[7]) begin
          k       = resolve(cmd_data, tmax(i));
          act[i]  = 1'b1;
          acc[i]  = cyc;
          mcmd[i] = cmd_data;
          mok[i]  = (k != 0);
          mend[i] = 2 * C * (8 + ((k != 0) ? k : tmax(i)));
        end else begin
          err_at[i] = cyc;
        end
      end
    end
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        j = cyc - acc[i];
        if (act[i] && mok[i] && (j == mend[i])) mrd[i] = mcmd[i];
      end
      chk("outs_a", {17'd0, dclk_a, cs_a, di_a, ready_a, rv_a, rt_a, err_a, rd_a}, {17'd0, expv(0)});
      chk("outs_b", {17'd0, dclk_b, cs_b, di_b, ready_b, rv_b, rt_b, err_b, rd_b}, {17'd0, expv(1)});
      for (int i = 0; i < 2; i++) begin
        j = cyc - acc[i];
        if (act[i] && (j >= mend[i] + 2 * C)) act[i] = 1'b0;
      end
      if (rv_a)  begin nrv[0]++; pj[0] = cyc - acc[0]; end
      if (rt_a)  begin nrt[0]++; pj[0] = cyc - acc[0]; end
      if (err_a) nerr[0]++;
      if (rv_b)  begin nrv[1]++; pj[1] = cyc - acc[1]; end
      if (rt_b)  begin nrt[1]++; pj[1] = cyc - acc[1]; end
      if (err_b) nerr[1]++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; mok[i] = 1'b0; acc[i] = 0; mend[i] = 0;
      err_at[i] = -1; mcmd[i] = 8'h00; mrd[i] = 8'h00;
    end
  endtask

  task automatic clr_obs();
    for (int i = 0; i < 2; i++) begin
      nrv[i] = 0; nrt[i] = 0; nerr[i] = 0; pj[i] = -1;
    end
  endtask

  task automatic set_stream(input logic [63:0] bits, input int len);
    stream_len = len;
    for (int k = 0; k < 64; k++) stream[k] = (k < len) ? bits[len - 1 - k] : 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    cmd_valid = 1'b1;
    cmd_data  = c;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 8'h3c;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < 1000) begin
      tick();
      n++;
    end
    checks++;
    if (act[0] || act[1]) begin
      failures++;
      $display("FAIL wait_idle: transfer still busy after %0d cycles", n);
    end
  endtask

  task automatic run(input logic [7:0] c, input logic [63:0] bits, input int len);
    set_stream(bits, len);
    clr_obs();
    send(c);
    wait_idle();
    tick();
  endtask

  initial begin
    model_reset();
    clr_obs();
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("rst_ready", {31'd0, ready_a}, 32'd1);
    chk("rst_clk_cs", {30'd0, dclk_a, cs_a}, 32'd0);
    chk("rst_resp_data", {24'd0, rd_a}, 32'd0);
    repeat (3) tick();
    #2 rst_n = 1'b1;
    repeat (4) tick();

    // echo of LEDOn; reply completes exactly on A's last allowed sample
    run(CmdLEDOn, {48'd0, 8'h01, 8'h81}, 16);
    chk("echo_rx_a", {24'd0, rx_a}, 32'h81);
    chk("echo_rx_b", {24'd0, rx_b}, 32'h81);
    chk("echo_rv_cnt_a", nrv[0], 32'd1);
    chk("echo_rt_cnt_a", nrt[0], 32'd0);
    chk("echo_pulse_at_a", pj[0], 32'd192);
    chk("echo_resp_a", {24'd0, rd_a}, 32'h81);

    // LEDOff with idle noise before the reply: A runs out, B finds it
    run(CmdLEDOff, {39'd0, 9'b000000010, 8'h01, 8'h80}, 25);
    chk("noise_rt_cnt_a", nrt[0], 32'd1);
    chk("noise_pulse_at_a", pj[0], 32'd192);
    chk("noise_rv_cnt_b", nrv[1], 32'd1);
    chk("noise_pulse_at_b", pj[1], 32'd264);
    chk("noise_resp_b", {24'd0, rd_b}, 32'h80);
    chk("noise_resp_a_held", {24'd0, rd_a}, 32'h81);

    // illegal command: error pulse only
    run(8'h05, 64'd0, 0);
    chk("bad_err_a", nerr[0], 32'd1);
    chk("bad_err_b", nerr[1], 32'd1);

    // silent target, plus a command offered while busy
    set_stream(64'd0, 0);
    clr_obs();
    send(CmdLEDOn);
    repeat (10) tick();
    cmd_valid = 1'b1;
    cmd_data  = CmdLEDOff;
    repeat (3) tick();
    cmd_valid = 1'b0;
    wait_idle();
    tick();
    chk("silent_pulse_at_a", pj[0], 32'd192);
    chk("silent_pulse_at_b", pj[1], 32'd320);
    chk("silent_rv_cnt_a", nrv[0], 32'd0);
    chk("silent_rv_cnt_b", nrv[1], 32'd0);

    // reply ending on B's last allowed sample
    run(CmdLEDOn, {32'd0, 16'h0000, 8'h01, 8'h81}, 32);
    chk("late_rv_cnt_b", nrv[1], 32'd1);
    chk("late_pulse_at_b", pj[1], 32'd320);
    chk("late_rt_cnt_a", nrt[0], 32'd1);

    // reset in the middle of the byte, with the serial clock high
    set_stream({48'd0, 8'h01, 8'h81}, 16);
    clr_obs();
    send(CmdLEDOn);
    while ((cyc - acc[0]) < 45) tick();
    chk("pre_rst_clk_high", {31'd0, dclk_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs_a", {25'd0, dclk_a, cs_a, di_a, rv_a, rt_a, err_a, (rd_a != 8'h00)}, 32'd0);
    chk("mid_rst_outs_b", {25'd0, dclk_b, cs_b, di_b, rv_b, rt_b, err_b, (rd_b != 8'h00)}, 32'd0);
    model_reset();
    repeat (3) tick();
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {30'd0, ready_a, ready_b}, 32'd3);
    run(CmdLEDOn, {48'd0, 8'h01, 8'h81}, 16);
    chk("fresh_rx_a", {24'd0, rx_a}, 32'h81);
    chk("fresh_resp_a", {24'd0, rd_a}, 32'h81);
    chk("fresh_rv_cnt_b", nrv[1], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
